// File: rtl/fifo_status.sv
`default_nettype none
// ============================================================================
// Module   : fifo_status
// Purpose  : Occupancy, hysteresis threshold and sticky error status for a
//            16-entry FIFO addressed by 5-bit wrap-bit pointers.
//            Optional peak-level tracking when FIFO_PEAK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_status #(
  parameter int THR_HI = 12,
  parameter int THR_LO = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] wptr,
  input  logic [4:0] rptr,
  input  logic       wr,
  input  logic       rd,
  input  logic       stat_clr,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic [4:0] fifo_level,
  output logic       fifo_threshold,
  output logic       fifo_overflow,
  output logic       fifo_underflow,
  output logic       fifo_ptr_err,
  output logic [4:0] fifo_peak
);

  localparam logic [4:0] c_thr_hi = 5'(THR_HI);
  localparam logic [4:0] c_thr_lo = 5'(THR_LO);
  localparam logic [4:0] c_depth  = 5'd16;

  typedef enum logic [0:0] {
    BELOW = 1'b0,
    ABOVE = 1'b1
  } thr_state_t;

  thr_state_t r_state;
  thr_state_t w_state_nxt;
  logic       w_threshold;
  logic [4:0] w_level;
  logic       w_ovf_set;
  logic       w_unf_set;
  logic       w_perr_set;
  logic       r_overflow;
  logic       r_underflow;
  logic       r_ptr_err;

  // Modulo-32 difference of wrap-bit pointers gives occupancy directly.
  assign w_level    = wptr - rptr;
  assign fifo_level = w_level;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[4] != rptr[4]) && (wptr[3:0] == rptr[3:0]);

  always_comb begin
    w_state_nxt = r_state;
    w_threshold = 1'b0;
    case (r_state)
      BELOW: begin
        w_threshold = 1'b0;
        if (w_level >= c_thr_hi) w_state_nxt = ABOVE;
      end
      ABOVE: begin
        w_threshold = 1'b1;
        if (w_level <= c_thr_lo) w_state_nxt = BELOW;
      end
      default: w_state_nxt = BELOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BELOW;
    else        r_state <= w_state_nxt;
  end

  assign fifo_threshold = w_threshold;

  assign w_ovf_set  = wr && fifo_full;
  assign w_unf_set  = rd && fifo_empty;
  assign w_perr_set = (w_level > c_depth);

  // A new set event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_ptr_err   <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set  | (r_overflow  & ~stat_clr);
      r_underflow <= w_unf_set  | (r_underflow & ~stat_clr);
      r_ptr_err   <= w_perr_set | (r_ptr_err   & ~stat_clr);
    end
  end

  assign fifo_overflow  = r_overflow;
  assign fifo_underflow = r_underflow;
  assign fifo_ptr_err   = r_ptr_err;

`ifdef FIFO_PEAK_EN
  logic [4:0] r_peak;

  // Clear restarts tracking from the present level; corrupt levels never load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peak <= 5'd0;
    end else if (stat_clr) begin
      r_peak <= (w_level <= c_depth) ? w_level : 5'd0;
    end else if ((w_level <= c_depth) && (w_level > r_peak)) begin
      r_peak <= w_level;
    end
  end

  assign fifo_peak = r_peak;
`else
  assign fifo_peak = 5'd0;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_status.md
FIFO_STATUS -- requirements
Module: fifo_status

Interface
REQ-001 Parameter THR_HI, default 12, level at or above which fifo_threshold asserts.
REQ-002 Parameter THR_LO, default 4, level at or below which fifo_threshold deasserts; legal only if THR_LO < THR_HI <= 16.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wptr  input  5  write pointer: [3:0] address, [4] wrap bit.
REQ-006 rptr  input  5  read pointer: same format as wptr.
REQ-007 wr  input  1  raw write request from the producer.
REQ-008 rd  input  1  raw read request from the consumer.
REQ-009 stat_clr  input  1  synchronous clear of sticky status.
REQ-010 fifo_empty  output  1  FIFO holds 0 entries.
REQ-011 fifo_full  output  1  FIFO holds 16 entries.
REQ-012 fifo_level  output  5  current occupancy, 0..16.
REQ-013 fifo_threshold  output  1  hysteresis occupancy flag.
REQ-014 fifo_overflow  output  1  sticky: write attempted while full.
REQ-015 fifo_underflow  output  1  sticky: read attempted while empty.
REQ-016 fifo_ptr_err  output  1  sticky: pointer difference exceeded 16.
REQ-017 fifo_peak  output  5  highest fifo_level seen since reset or last stat_clr.

Function
REQ-018 fifo_level shall be combinational: (wptr - rptr) modulo 32, 5 bits.
REQ-019 fifo_empty shall be combinational: 1 iff wptr == rptr (all 5 bits), so the read-gating stage sees it in the same cycle.
REQ-020 fifo_full shall be combinational: 1 iff wptr[4] != rptr[4] and wptr[3:0] == rptr[3:0].
REQ-021 Threshold FSM shall have two states, BELOW (fifo_threshold=0) and ABOVE (fifo_threshold=1); BELOW->ABOVE when fifo_level >= THR_HI; ABOVE->BELOW when fifo_level <= THR_LO; otherwise hold.
REQ-022 fifo_overflow shall set on the edge where wr=1 and fifo_full=1, regardless of rd in that cycle.
REQ-023 fifo_underflow shall set on the edge where rd=1 and fifo_empty=1, regardless of wr in that cycle.
REQ-024 fifo_ptr_err shall set on the edge where fifo_level > 16; while set, fifo_level is still driven per REQ-018.
REQ-025 Sticky flags shall hold until stat_clr=1 or reset; stat_clr clears them on the next edge.
REQ-026 If a set condition and stat_clr coincide, the flag shall be 1 after that edge (set wins).
REQ-027 fifo_peak shall load fifo_level on any edge where fifo_level > fifo_peak, values > 16 excluded.
REQ-028 On stat_clr, fifo_peak shall load the current fifo_level (not 0).
REQ-029 Outputs derived from registers shall change only on the rising clk edge; no combinational path from wr/rd to any output.

Reset
REQ-030 rst_n=0 shall immediately force: FSM=BELOW, fifo_threshold=0, fifo_overflow=0, fifo_underflow=0, fifo_ptr_err=0, fifo_peak=0.
REQ-031 During reset, combinational outputs shall track the pointers (which the pointer stages hold at 0, giving fifo_empty=1, fifo_full=0, fifo_level=0).
REQ-032 Reset asserted mid-operation shall discard all sticky and FSM state; release shall not itself set any flag.

Configuration
REQ-033 Macro FIFO_PEAK_EN: defined -> fifo_peak tracked per REQ-027/028; undefined -> peak register not built, fifo_peak tied to 5'd0, port list unchanged.

Verification
REQ-034 Reset, wptr=rptr=0 -> fifo_empty=1, fifo_full=0, fifo_level=0, all sticky flags 0, fifo_peak=0.
REQ-035 wptr=5'b10000, rptr=0, pulse wr=1 and rd=1 one cycle -> fifo_full=1, fifo_level=16, fifo_overflow=1 next edge, fifo_underflow=0.
REQ-036 Step level 0->12->8->4->3 (defaults) -> fifo_threshold 0,1,1,0,0.
REQ-037 wptr=rptr=5'd7, rd=1 with stat_clr=1 same cycle -> fifo_underflow=1 after edge; stat_clr alone next cycle -> 0.
REQ-038 Level 0->9->5, stat_clr, then 6 -> fifo_peak 9,9,5,6 with FIFO_PEAK_EN; constant 0 without.
REQ-039 wptr=5'd20, rptr=0 -> fifo_level=20, fifo_ptr_err=1 next edge, fifo_peak unchanged; assert rst_n=0 -> fifo_ptr_err=0 immediately.
